// File: rtl/nd_1ton.sv
// nd_1ton: 1-to-NOUT comparator routing node for the messaging-cells fabric.
// Each received word is classified against per-output operator/reference
// pairs (lowest matching entry wins, else DFLT_OUT; DFLT_OUT >= NOUT drops),
// buffered in a per-output FIFO and re-issued on a four-phase send channel.
// Optional build macro: NS_ND_1TON_SYNC_EN adds 2-flop synchronisers on
// rcv0_req and every snd_ack for peers on unrelated clocks.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 32
`endif
`ifndef NS_EQ_OP
`define NS_EQ_OP 4'd0
`endif
`ifndef NS_NE_OP
`define NS_NE_OP 4'd1
`endif
`ifndef NS_LT_OP
`define NS_LT_OP 4'd2
`endif
`ifndef NS_GT_OP
`define NS_GT_OP 4'd3
`endif
`ifndef NS_LE_OP
`define NS_LE_OP 4'd4
`endif
`ifndef NS_GE_OP
`define NS_GE_OP 4'd5
`endif

module nd_1ton #(
  parameter int unsigned           ASZ      = `NS_ADDRESS_SIZE,
  parameter int unsigned           DSZ      = `NS_DATA_SIZE,
  parameter int unsigned           NOUT     = 4,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [NOUT*4-1:0]     OPERS    = '0,
  parameter logic [NOUT*DSZ-1:0]   REF_VALS = '0,
  parameter int unsigned           DFLT_OUT = NOUT
) (
  input  logic                  i_clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic [DSZ-1:0]        rcv0_dat,
  input  logic                  rcv0_req,
  output logic                  rcv0_ack,
  output logic [NOUT*DSZ-1:0]   snd_dat,
  output logic [NOUT-1:0]       snd_req,
  input  logic [NOUT-1:0]       snd_ack,
  output logic                  o_err
);

  localparam int unsigned TW = $clog2(NOUT + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [TW-1:0] DROP_T = TW'(NOUT);
  localparam logic [TW-1:0] DFLT_T = (DFLT_OUT < NOUT) ? TW'(DFLT_OUT) : DROP_T;

  if (NOUT < 2 || NOUT > 8) begin : g_bad_nout
    $error("nd_1ton: NOUT must be in 2..8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("nd_1ton: DEPTH must be a power of two, at least 2");
  end
  if (ASZ > DSZ) begin : g_bad_asz
    $error("nd_1ton: address field wider than the data word");
  end

  typedef enum logic {R_IDLE, R_ACK} rcv_state_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOW} snd_state_t;

  rcv_state_t       r_state, r_next;
  snd_state_t       s_state [NOUT];
  snd_state_t       s_next  [NOUT];

  logic             req_s;
  logic [NOUT-1:0]  ack_s;

  logic [NOUT-1:0]  hit;
  logic [TW-1:0]    tgt;
  logic             rx_go, take_now, drop_now;
  logic [NOUT-1:0]  wr_en, pop, full, empty;
  logic [NOUT:0]    full_x;

  logic [DSZ-1:0]   mem    [NOUT][DEPTH];
  logic [AW-1:0]    wr_ptr [NOUT];
  logic [AW-1:0]    rd_ptr [NOUT];
  logic [CW-1:0]    cnt    [NOUT];

`ifdef NS_ND_1TON_SYNC_EN
  logic [1:0]       req_sync;
  logic [NOUT-1:0]  ack_sync1, ack_sync2;

  // Two-flop synchronisers for the handshake inputs from foreign clock domains
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      req_sync  <= '0;
      ack_sync1 <= '0;
      ack_sync2 <= '0;
    end else begin
      req_sync  <= {req_sync[0], rcv0_req};
      ack_sync1 <= snd_ack;
      ack_sync2 <= ack_sync1;
    end
  end

  assign req_s = req_sync[1];
  assign ack_s = ack_sync2;
`else
  assign req_s = rcv0_req;
  assign ack_s = snd_ack;
`endif

  // Node is ready from the first clock edge after reset release
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) ready <= 1'b0;
    else       ready <= 1'b1;
  end

  // Per-entry unsigned comparison; unknown operator codes never match
  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < NOUT; k++) begin
      case (OPERS[4*k +: 4])
        `NS_EQ_OP: hit[k] = (rcv0_dat == REF_VALS[DSZ*k +: DSZ]);
        `NS_NE_OP: hit[k] = (rcv0_dat != REF_VALS[DSZ*k +: DSZ]);
        `NS_LT_OP: hit[k] = (rcv0_dat <  REF_VALS[DSZ*k +: DSZ]);
        `NS_GT_OP: hit[k] = (rcv0_dat >  REF_VALS[DSZ*k +: DSZ]);
        `NS_LE_OP: hit[k] = (rcv0_dat <= REF_VALS[DSZ*k +: DSZ]);
        `NS_GE_OP: hit[k] = (rcv0_dat >= REF_VALS[DSZ*k +: DSZ]);
        default:   hit[k] = 1'b0;
      endcase
    end
  end

  // Lowest matching entry wins; scanning downward lets lower k overwrite
  always_comb begin
    tgt = DFLT_T;
    for (int unsigned k = NOUT; k > 0; k--) begin
      if (hit[k-1]) tgt = TW'(k - 1);
    end
  end

  // Ingress accept/drop decision; full is the pre-edge count, so a same-edge pop does not help
  always_comb begin
    full_x   = {1'b1, full};
    rx_go    = (r_state == R_IDLE) && ready && req_s;
    drop_now = rx_go && (tgt == DROP_T);
    take_now = rx_go && (tgt != DROP_T) && !full_x[tgt];
  end

  // Ingress state register
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  // Ingress next state: a full target keeps us idle with ack low (head-of-line block)
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (take_now || drop_now) r_next = R_ACK;
      R_ACK:   if (!req_s) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Ingress outputs: ack while in R_ACK, one-hot FIFO write on acceptance
  always_comb begin
    rcv0_ack = (r_state == R_ACK);
    for (int unsigned k = 0; k < NOUT; k++) begin
      wr_en[k] = take_now && (tgt == TW'(k));
    end
  end

  // Sticky routing error, cleared only by reset
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset)         o_err <= 1'b0;
    else if (drop_now) o_err <= 1'b1;
  end

  // FIFO storage, not reset: contents are only visible through the pointers
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NOUT; k++) begin
      if (wr_en[k]) mem[k][wr_ptr[k]] <= rcv0_dat;
    end
  end

  // FIFO pointers and occupancy; reset flushes every queue
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop[k])   rd_ptr[k] <= rd_ptr[k] + AW'(1);
        cnt[k] <= cnt[k] + CW'(wr_en[k]) - CW'(pop[k]);
      end
    end
  end

  // FIFO status flags
  always_comb begin
    for (int unsigned k = 0; k < NOUT; k++) begin
      full[k]  = (cnt[k] == CW'(DEPTH));
      empty[k] = (cnt[k] == '0);
    end
  end

  // Egress state registers
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NOUT; k++) s_state[k] <= S_IDLE;
    end else begin
      for (int unsigned k = 0; k < NOUT; k++) s_state[k] <= s_next[k];
    end
  end

  // Egress next state per output channel
  always_comb begin
    for (int unsigned k = 0; k < NOUT; k++) begin
      s_next[k] = s_state[k];
      case (s_state[k])
        S_IDLE:  if (!empty[k]) s_next[k] = S_WAIT;
        S_WAIT:  if (ack_s[k])  s_next[k] = S_LOW;
        S_LOW:   if (!ack_s[k]) s_next[k] = S_IDLE;
        default: s_next[k] = S_IDLE;
      endcase
    end
  end

  // Egress outputs: head word shown only while requesting, so idle/reset data reads 0
  always_comb begin
    snd_req = '0;
    pop     = '0;
    snd_dat = '0;
    for (int unsigned k = 0; k < NOUT; k++) begin
      if (s_state[k] == S_WAIT) begin
        snd_req[k]             = 1'b1;
        pop[k]                 = ack_s[k];
        snd_dat[DSZ*k +: DSZ]  = mem[k][rd_ptr[k]];
      end
    end
  end

endmodule
